bus_drvr_fifo: RTL and testbench

BUS_DRVR_FIFO -- requirements
Module: bus_drvr_fifo

---
 rtl/bus_drvr_fifo.sv | 104 ++++++++++
 tb/tb_bus_drvr_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_drvr_fifo.sv
// Driver-side packet FIFO with first-word fall-through read port.
// Occupancy flags plus sticky overflow/underflow error reporting.
module bus_drvr_fifo #(
   parameter int pckg_sz = 16,
   parameter int depth   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [pckg_sz-1:0]       D_push,
   input  logic                     pop,
   output logic [pckg_sz-1:0]       D_pop,
   output logic                     pndng,
   output logic                     full,
   output logic [$clog2(depth):0]   count,
   output logic                     ovf,
   output logic                     udf,
   output logic [7:0]               ovf_cnt,
   input  logic                     clr_err
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;

   logic [pckg_sz-1:0] mem [depth];

   logic [AW-1:0] wrPtr_q, wrPtr_d;
   logic [AW-1:0] rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic [7:0]    ovfCnt_q, ovfCnt_d;

   logic isEmpty, isFull, popOk, pushOk, pushDropped;

   assign isEmpty     = (count_q == '0);
   assign isFull      = (count_q == CW'(depth));
   assign popOk       = pop && !isEmpty;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign pushOk      = push && (!isFull || popOk);
   assign pushDropped = push && !pushOk;

   always_comb begin
      wrPtr_d  = wrPtr_q;
      rdPtr_d  = rdPtr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      ovfCnt_d = ovfCnt_q;

      if (pushOk) wrPtr_d = wrPtr_q + AW'(1);
      if (popOk)  rdPtr_d = rdPtr_q + AW'(1);

      case ({pushOk, popOk})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (clr_err) begin
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
         ovfCnt_d = '0;
      end else begin
         if (pop && isEmpty) udf_d = 1'b1;
         if (pushDropped) begin
            ovf_d = 1'b1;
            if (ovfCnt_q != 8'hFF) ovfCnt_d = ovfCnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q  <= '0;
         rdPtr_q  <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         ovfCnt_q <= '0;
      end else begin
         wrPtr_q  <= wrPtr_d;
         rdPtr_q  <= rdPtr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         ovfCnt_q <= ovfCnt_d;
      end
   end

   // Storage is not reset; emptiness is tracked by count alone.
   always_ff @(posedge clk) begin
      if (pushOk && !reset) mem[wrPtr_q] <= D_push;
   end

   assign D_pop   = isEmpty ? '0 : mem[rdPtr_q];
   assign pndng   = !isEmpty;
   assign full    = isFull;
   assign count   = count_q;
   assign ovf     = ovf_q;
   assign udf     = udf_q;
   assign ovf_cnt = ovfCnt_q;

endmodule

// File: tb/tb_bus_drvr_fifo.sv
// Testbench for bus_drvr_fifo: table vectors, directed corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_bus_drvr_fifo;

   localparam int W     = 16;
   localparam int DEPTH = 8;

   logic          clk, reset, push, pop, clr_err;
   logic [W-1:0]  D_push, D_pop;
   logic          pndng, full, ovf, udf;
   logic [3:0]    count;
   logic [7:0]    ovf_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state: plain queue plus error flags.
   logic [W-1:0] mq[$];
   bit           mOvf, mUdf;
   int           mOvfCnt;

   typedef struct {
      bit          p;
      bit          q;
      logic [15:0] d;
      bit          c;
      int          expCount;
      int          expDpop;
      bit          expPndng;
   } vec_t;

   vec_t vecs[9];

   bus_drvr_fifo #(.pckg_sz(W), .depth(DEPTH)) dut (
      .clk(clk), .reset(reset), .push(push), .D_push(D_push), .pop(pop),
      .D_pop(D_pop), .pndng(pndng), .full(full), .count(count),
      .ovf(ovf), .udf(udf), .ovf_cnt(ovf_cnt), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then step past the edge.
   task automatic applyStimulus(input bit p, input bit q, input logic [15:0] d,
                                input bit c, input bit r);
      bit popOk, pushOk;
      push = p; pop = q; D_push = d; clr_err = c; reset = r;
      if (r) begin
         mq.delete();
         mOvf = 0; mUdf = 0; mOvfCnt = 0;
      end else begin
         popOk  = q && (mq.size() > 0);
         pushOk = p && ((mq.size() < DEPTH) || popOk);
         if (c) begin
            mOvf = 0; mUdf = 0; mOvfCnt = 0;
         end else begin
            if (q && mq.size() == 0) mUdf = 1;
            if (p && !pushOk) begin
               mOvf = 1;
               if (mOvfCnt < 255) mOvfCnt++;
            end
         end
         if (popOk)  void'(mq.pop_front());
         if (pushOk) mq.push_back(d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput();
      check("count",   int'(count),   mq.size());
      check("pndng",   int'(pndng),   int'(mq.size() != 0));
      check("full",    int'(full),    int'(mq.size() == DEPTH));
      check("D_pop",   int'(D_pop),   (mq.size() != 0) ? int'(mq[0]) : 0);
      check("ovf",     int'(ovf),     int'(mOvf));
      check("udf",     int'(udf),     int'(mUdf));
      check("ovf_cnt", int'(ovf_cnt), mOvfCnt);
   endtask

   initial begin
      logic [15:0] expList[8];
      int          pushPct;

      clk = 0; reset = 1; push = 0; pop = 0; clr_err = 0; D_push = '0;

      // Reset state
      applyStimulus(0, 0, 16'h0, 0, 1);
      applyStimulus(0, 0, 16'h0, 0, 1);
      check("rst_count", int'(count), 0);
      check("rst_pndng", int'(pndng), 0);
      check("rst_full",  int'(full), 0);
      check("rst_dpop",  int'(D_pop), 0);
      check("rst_ovf",   int'(ovf), 0);
      check("rst_udf",   int'(udf), 0);
      check("rst_ovfcnt", int'(ovf_cnt), 0);

      // Basic ordering, empty push+pop, error clear
      vecs[0] = '{1, 0, 16'h0A01, 0, 1, 16'h0A01, 1};
      vecs[1] = '{1, 0, 16'h0B02, 0, 2, 16'h0A01, 1};
      vecs[2] = '{1, 0, 16'h0C03, 0, 3, 16'h0A01, 1};
      vecs[3] = '{0, 1, 16'h0000, 0, 2, 16'h0B02, 1};
      vecs[4] = '{0, 1, 16'h0000, 0, 1, 16'h0C03, 1};
      vecs[5] = '{0, 1, 16'h0000, 0, 0, 16'h0000, 0};
      vecs[6] = '{1, 1, 16'h1234, 0, 1, 16'h1234, 1};
      vecs[7] = '{0, 1, 16'h0000, 0, 0, 16'h0000, 0};
      vecs[8] = '{0, 0, 16'h0000, 1, 0, 16'h0000, 0};
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].p, vecs[i].q, vecs[i].d, vecs[i].c, 0);
         check($sformatf("vec%0d_count", i), int'(count), vecs[i].expCount);
         check($sformatf("vec%0d_dpop", i),  int'(D_pop), vecs[i].expDpop);
         check($sformatf("vec%0d_pndng", i), int'(pndng), int'(vecs[i].expPndng));
         if (i == 6) check("vec6_udf", int'(udf), 1);
         if (i == 8) check("vec8_udf_clr", int'(udf), 0);
         checkOutput();
      end

      // Overflow drop while full, then drain in order
      applyStimulus(0, 0, 16'h0, 0, 1);
      for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 16'(i), 0, 0);
      applyStimulus(1, 0, 16'h0009, 0, 0);
      check("ovf_full", int'(full), 1);
      check("ovf_flag", int'(ovf), 1);
      check("ovf_cnt1", int'(ovf_cnt), 1);
      check("ovf_count", int'(count), 8);
      for (int i = 1; i <= 8; i++) begin
         check("ovf_drain", int'(D_pop), i);
         applyStimulus(0, 1, 16'h0, 0, 0);
         checkOutput();
      end
      check("ovf_drained", int'(pndng), 0);

      // Push+pop while full
      applyStimulus(0, 0, 16'h0, 0, 1);
      for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 16'(i), 0, 0);
      applyStimulus(1, 1, 16'h00AA, 0, 0);
      check("fullpp_count", int'(count), 8);
      check("fullpp_head", int'(D_pop), 2);
      check("fullpp_ovf", int'(ovf), 0);
      for (int i = 0; i < 8; i++) begin
         check("fullpp_drain", int'(D_pop), (i < 7) ? i + 2 : 16'h00AA);
         applyStimulus(0, 1, 16'h0, 0, 0);
      end
      check("fullpp_empty", int'(count), 0);

      // Saturating drop counter, then clear beats a same-cycle drop
      for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 16'(i), 0, 0);
      for (int i = 0; i < 300; i++) applyStimulus(1, 0, 16'hFFFF, 0, 0);
      check("sat_ovfcnt", int'(ovf_cnt), 255);
      applyStimulus(1, 0, 16'hEEEE, 1, 0);
      check("clr_ovf", int'(ovf), 0);
      check("clr_ovfcnt", int'(ovf_cnt), 0);
      check("clr_count", int'(count), 8);
      checkOutput();

      // Pointer wrap ordering
      applyStimulus(0, 0, 16'h0, 0, 1);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 16'h0050 + 16'(i), 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 16'h0, 0, 0);
      for (int i = 0; i < 6; i++) applyStimulus(1, 0, 16'h0060 + 16'(i), 0, 0);
      check("wrap_count", int'(count), 8);
      expList = '{16'h0053, 16'h0054, 16'h0060, 16'h0061,
                  16'h0062, 16'h0063, 16'h0064, 16'h0065};
      for (int i = 0; i < 8; i++) begin
         check("wrap_order", int'(D_pop), int'(expList[i]));
         applyStimulus(0, 1, 16'h0, 0, 0);
      end

      // Reset while full, overriding push/pop/clr
      for (int i = 0; i < 8; i++) applyStimulus(1, 0, 16'h0070 + 16'(i), 0, 0);
      check("prerst_count", int'(count), 8);
      applyStimulus(1, 1, 16'h7777, 1, 1);
      check("rstfull_count", int'(count), 0);
      check("rstfull_pndng", int'(pndng), 0);
      check("rstfull_dpop", int'(D_pop), 0);
      applyStimulus(0, 0, 16'h0, 0, 0);
      check("rstfull_stale", int'(pndng), 0);

      // Randomized traffic against the reference model
      for (int i = 0; i < 4000; i++) begin
         pushPct = ((i / 500) % 2 == 0) ? 70 : 35;
         applyStimulus($urandom_range(0, 99) < pushPct,
                       $urandom_range(0, 99) < 50,
                       16'($urandom),
                       $urandom_range(0, 99) < 3,
                       $urandom_range(0, 999) < 2);
         checkOutput();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
